// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: main-pipeline request, MDU result offer, and the
// registered register-file / HI-LO write port.
interface wb_port_arbiter_if;
    logic        pipe_valid;
    logic [4:0]  pipe_rfaddr;
    logic [31:0] pipe_rfdata;
    logic        pipe_rf_allow;

    logic        mdu_valid;
    logic [4:0]  mdu_rfaddr;
    logic [31:0] mdu_rfdata;
    logic        mdu_rf_allow;
    logic        mdu_hilo_allow;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;

    logic        mdu_ready;
    logic        pipe_stall;

    logic [4:0]  wb_rfaddr_out;
    logic [31:0] wb_rf_out;
    logic        wb_rf_allow;
    logic [31:0] wb_hi_out;
    logic [31:0] wb_lo_out;
    logic        wb_hilo_allow;

    modport master (
        output pipe_valid, pipe_rfaddr, pipe_rfdata, pipe_rf_allow,
        output mdu_valid, mdu_rfaddr, mdu_rfdata, mdu_rf_allow,
        output mdu_hilo_allow, mdu_hi, mdu_lo,
        input  mdu_ready, pipe_stall,
        input  wb_rfaddr_out, wb_rf_out, wb_rf_allow,
        input  wb_hi_out, wb_lo_out, wb_hilo_allow
    );

    modport slave (
        input  pipe_valid, pipe_rfaddr, pipe_rfdata, pipe_rf_allow,
        input  mdu_valid, mdu_rfaddr, mdu_rfdata, mdu_rf_allow,
        input  mdu_hilo_allow, mdu_hi, mdu_lo,
        output mdu_ready, pipe_stall,
        output wb_rfaddr_out, wb_rf_out, wb_rf_allow,
        output wb_hi_out, wb_lo_out, wb_hilo_allow
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file writeback port between the main pipeline and a
// 2-deep MDU result FIFO, forcing a one-cycle drain when the MDU is starved.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4   // legal range 1..7 (3-bit counter)
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);

    typedef struct packed {
        logic [4:0]  rfaddr;
        logic [31:0] rfdata;
        logic        rf_allow;
        logic        hilo_allow;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_entry_t;

    typedef enum logic {NORMAL, DRAIN} state_t;

    function automatic logic rf_write_en(input logic allow, input logic [4:0] addr);
        return allow && (addr != 5'd0);
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  count_after_pop;
    mdu_entry_t  fifo_q [2];
    mdu_entry_t  fifo_d [2];
    mdu_entry_t  push_entry;
    mdu_entry_t  head;
    logic        fifo_empty, push, pop, grant_pipe, waw_en;

    logic [4:0]  wb_rfaddr_p1;
    logic [31:0] wb_rf_p1;
    logic        wb_rf_allow_p1;
    logic [31:0] wb_hi_p1;
    logic [31:0] wb_lo_p1;
    logic        wb_hilo_allow_p1;

    assign head           = fifo_q[0];
    assign fifo_empty     = (count_q == 2'd0);
    assign bus.mdu_ready  = (count_q != 2'd2);
    assign bus.pipe_stall = (state_q == DRAIN);
    assign push           = bus.mdu_valid && bus.mdu_ready;

    // Arbitration FSM and starvation counter
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        grant_pipe = 1'b0;
        pop        = 1'b0;
        case (state_q)
            NORMAL: begin
                if (bus.pipe_valid) begin
                    grant_pipe = 1'b1;
                    if (!fifo_empty) begin
                        starve_d = starve_q + 3'd1;
                        if (int'(starve_q) + 1 >= STARVE_LIMIT) state_d = DRAIN;
                    end else begin
                        starve_d = 3'd0;
                    end
                end else begin
                    pop      = !fifo_empty;
                    starve_d = 3'd0;
                end
            end
            DRAIN: begin
                pop      = !fifo_empty;
                state_d  = NORMAL;
                starve_d = 3'd0;
            end
            default: state_d = NORMAL;
        endcase
    end

    // FIFO next state; a pipeline write kills older queued writes to the same register
    always_comb begin
        waw_en = grant_pipe && rf_write_en(bus.pipe_rf_allow, bus.pipe_rfaddr);

        push_entry.rfaddr     = bus.mdu_rfaddr;
        push_entry.rfdata     = bus.mdu_rfdata;
        push_entry.rf_allow   = bus.mdu_rf_allow;
        push_entry.hilo_allow = bus.mdu_hilo_allow;
        push_entry.hi         = bus.mdu_hi;
        push_entry.lo         = bus.mdu_lo;
        if (waw_en && push_entry.rfaddr == bus.pipe_rfaddr) push_entry.rf_allow = 1'b0;

        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        for (int i = 0; i < 2; i++) begin
            if (waw_en && fifo_q[i].rfaddr == bus.pipe_rfaddr) fifo_d[i].rf_allow = 1'b0;
        end

        if (pop) fifo_d[0] = fifo_q[1];
        count_after_pop = count_q - {1'b0, pop};
        if (push) begin
            if (count_after_pop == 2'd0) fifo_d[0] = push_entry;
            else                         fifo_d[1] = push_entry;
        end
        count_d = count_after_pop + {1'b0, push};
    end

    always_ff @(posedge clk) begin
        fifo_q[0] <= fifo_d[0];
        fifo_q[1] <= fifo_d[1];
    end

    // Stage p1: registered writeback port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= NORMAL;
            starve_q         <= 3'd0;
            count_q          <= 2'd0;
            wb_rfaddr_p1     <= 5'd0;
            wb_rf_p1         <= 32'd0;
            wb_rf_allow_p1   <= 1'b0;
            wb_hi_p1         <= 32'd0;
            wb_lo_p1         <= 32'd0;
            wb_hilo_allow_p1 <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            count_q  <= count_d;
            if (grant_pipe) begin
                wb_rfaddr_p1     <= bus.pipe_rfaddr;
                wb_rf_p1         <= bus.pipe_rfdata;
                wb_rf_allow_p1   <= rf_write_en(bus.pipe_rf_allow, bus.pipe_rfaddr);
                wb_hilo_allow_p1 <= 1'b0;
            end else if (pop) begin
                wb_rfaddr_p1     <= head.rfaddr;
                wb_rf_p1         <= head.rfdata;
                wb_rf_allow_p1   <= rf_write_en(head.rf_allow, head.rfaddr);
                wb_hi_p1         <= head.hi;
                wb_lo_p1         <= head.lo;
                wb_hilo_allow_p1 <= head.hilo_allow;
            end else begin
                wb_rf_allow_p1   <= 1'b0;
                wb_hilo_allow_p1 <= 1'b0;
            end
        end
    end

    assign bus.wb_rfaddr_out = wb_rfaddr_p1;
    assign bus.wb_rf_out     = wb_rf_p1;
    assign bus.wb_rf_allow   = wb_rf_allow_p1;
    assign bus.wb_hi_out     = wb_hi_p1;
    assign bus.wb_lo_out     = wb_lo_p1;
    assign bus.wb_hilo_allow = wb_hilo_allow_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: driver runs a queue-based reference model at the falling
// edge, a monitor compares the registered write port after each rising edge.
module tb_wb_port_arbiter;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        rf_al;
        logic        hl_al;
        logic [31:0] hi;
        logic [31:0] lo;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();
    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    ent_t exp_q[$];
    ent_t mq[$];
    ent_t last_out;
    int   m_starve;
    bit   m_drain;
    bit   known = 0;

    bit   off_v = 0;
    ent_t off_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the write port one cycle after each modelled decision
    always @(posedge clk) begin
        ent_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_rf_allow",   32'(bus.wb_rf_allow),   32'(e.rf_al));
            chk("wb_hilo_allow", 32'(bus.wb_hilo_allow), 32'(e.hl_al));
            chk("wb_rfaddr_out", 32'(bus.wb_rfaddr_out), 32'(e.addr));
            chk("wb_rf_out",     bus.wb_rf_out,          e.data);
            chk("wb_hi_out",     bus.wb_hi_out,          e.hi);
            chk("wb_lo_out",     bus.wb_lo_out,          e.lo);
        end
    end

    task automatic offer(input logic [4:0] a, input logic [31:0] d, input bit ral,
                         input bit hl, input logic [31:0] hi, input logic [31:0] lo);
        if (!off_v) begin
            off_v = 1;
            off_e = '{addr: a, data: d, rf_al: ral, hl_al: hl, hi: hi, lo: lo};
        end
    endtask

    task automatic step(input bit r, input bit pv, input logic [4:0] pa,
                        input logic [31:0] pd, input bit pal);
        ent_t e, ne, h0;
        bit rdy, take;
        @(negedge clk);
        rdy = (mq.size() < 2);
        if (known) begin
            chk("mdu_ready",  32'(bus.mdu_ready),  32'(rdy));
            chk("pipe_stall", 32'(bus.pipe_stall), 32'(m_drain));
        end
        if (!r) off_v = 0;
        rst_n              = r;
        bus.pipe_valid     = pv;
        bus.pipe_rfaddr    = pa;
        bus.pipe_rfdata    = pd;
        bus.pipe_rf_allow  = pal;
        bus.mdu_valid      = off_v;
        bus.mdu_rfaddr     = off_e.addr;
        bus.mdu_rfdata     = off_e.data;
        bus.mdu_rf_allow   = off_e.rf_al;
        bus.mdu_hilo_allow = off_e.hl_al;
        bus.mdu_hi         = off_e.hi;
        bus.mdu_lo         = off_e.lo;

        if (!r) begin
            mq.delete();
            m_starve = 0;
            m_drain  = 0;
            last_out = '0;
            known    = 1;
            exp_q.push_back('0);
            return;
        end

        take = off_v && rdy;
        ne = off_e;
        e = last_out;
        e.rf_al = 0;
        e.hl_al = 0;
        if (m_drain) begin
            if (mq.size() > 0) begin
                h0 = mq.pop_front();
                e = h0;
                e.rf_al = h0.rf_al && (h0.addr != 0);
            end
            m_drain  = 0;
            m_starve = 0;
        end else if (pv) begin
            e.addr  = pa;
            e.data  = pd;
            e.rf_al = pal && (pa != 0);
            if (pal && pa != 0) begin
                foreach (mq[i]) if (mq[i].addr == pa) mq[i].rf_al = 0;
                if (ne.addr == pa) ne.rf_al = 0;
            end
            if (mq.size() > 0) begin
                m_starve++;
                if (m_starve >= LIMIT) m_drain = 1;
            end else begin
                m_starve = 0;
            end
        end else begin
            if (mq.size() > 0) begin
                h0 = mq.pop_front();
                e = h0;
                e.rf_al = h0.rf_al && (h0.addr != 0);
            end
            m_starve = 0;
        end
        if (take) begin
            mq.push_back(ne);
            off_v = 0;
        end
        last_out = e;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 5'd0, 32'd0, 0);
    endtask

    task automatic wait_offer_taken(input string name, input bit pv);
        int cyc = 0;
        while (off_v && cyc < 20) begin
            step(1, pv, 5'd3, $urandom, 1);
            cyc++;
        end
        chk(name, 32'(off_v), 32'd0);
    endtask

    initial begin
        off_e = '0;
        bus.pipe_valid = 0;  bus.pipe_rfaddr = 0;  bus.pipe_rfdata = 0;  bus.pipe_rf_allow = 0;
        bus.mdu_valid = 0;   bus.mdu_rfaddr = 0;   bus.mdu_rfdata = 0;   bus.mdu_rf_allow = 0;
        bus.mdu_hilo_allow = 0; bus.mdu_hi = 0;    bus.mdu_lo = 0;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Plain pipeline write
        step(1, 1, 5'd5, 32'h1234, 1);
        idle(1);

        // MDU HI/LO-only result to r0
        offer(5'd0, 32'hDEAD, 1, 1, 32'hA, 32'hB);
        idle(3);

        // Starvation: one queued entry behind a continuous pipeline
        offer(5'd9, 32'h9999, 1, 0, 32'h1, 32'h2);
        for (int i = 0; i < 9; i++) step(1, 1, 5'(10 + i), 32'h100 + i, 1);
        idle(1);

        // Three back-to-back offers with the pipeline busy
        offer(5'd11, 32'hB1, 1, 0, 0, 0);
        step(1, 1, 5'd2, 32'h2, 1);
        offer(5'd12, 32'hB2, 1, 1, 32'h22, 32'h33);
        step(1, 1, 5'd2, 32'h3, 1);
        offer(5'd13, 32'hB3, 1, 0, 0, 0);
        wait_offer_taken("third_push_taken", 1);
        idle(4);

        // WAW: queued entry and same-cycle push both lose their rf write
        offer(5'd7, 32'h77, 1, 1, 32'h70, 32'h71);
        step(1, 1, 5'd3, 32'h33, 1);
        offer(5'd9, 32'h99, 1, 0, 0, 0);
        step(1, 1, 5'd7, 32'h707, 1);
        step(1, 1, 5'd9, 32'h909, 1);
        idle(4);

        // Entry with no enables still pops
        offer(5'd4, 32'h44, 0, 0, 32'h5, 32'h6);
        idle(3);

        // Reset with two entries queued
        offer(5'd20, 32'h2020, 1, 1, 32'h1, 32'h1);
        step(1, 1, 5'd1, 32'h1, 1);
        offer(5'd21, 32'h2121, 1, 1, 32'h2, 32'h2);
        step(1, 1, 5'd1, 32'h2, 1);
        step(0, 0, 0, 0, 0);
        idle(4);

        // Randomized traffic with a narrow address range to provoke collisions
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 45)
                offer(5'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom),
                      $urandom, $urandom);
            step(($urandom_range(0, 79) != 0), ($urandom_range(0, 99) < 60),
                 5'($urandom_range(0, 7)), $urandom, 1'($urandom));
        end
        idle(6);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have ports pipe_valid / pipe_rfaddr / pipe_rfdata / pipe_rf_allow, input, 1/5/32/1, main-pipeline writeback request: valid, destination register, data, write enable.
REQ-004 SHALL have ports mdu_valid / mdu_rfaddr / mdu_rfdata / mdu_rf_allow, input, 1/5/32/1, multi-cycle mul/div unit result offered to the register file.
REQ-005 SHALL have ports mdu_hilo_allow / mdu_hi / mdu_lo, input, 1/32/32, MDU HI/LO write enable and data.
REQ-006 SHALL have port mdu_ready, output, 1, MDU result accepted this cycle when mdu_valid=1.
REQ-007 SHALL have port pipe_stall, output, 1, main pipeline must hold its writeback request; request ignored this cycle.
REQ-008 SHALL have ports wb_rfaddr_out / wb_rf_out / wb_rf_allow, output, 5/32/1, registered register-file write port.
REQ-009 SHALL have ports wb_hi_out / wb_lo_out / wb_hilo_allow, output, 32/32/1, registered HI/LO write port.
REQ-010 SHALL have parameter STARVE_LIMIT, default 4, consecutive pipeline grants tolerated while the MDU queue is non-empty.

Function
REQ-011 SHALL hold MDU results in a 2-entry FIFO (rfaddr, rfdata, rf_allow, hilo_allow, hi, lo); mdu_ready = (count < 2), driven from registered state only.
REQ-012 SHALL push on mdu_valid && mdu_ready; push and pop in the same cycle SHALL be allowed and leave count unchanged.
REQ-013 SHALL use FSM states NORMAL and DRAIN.
REQ-014 In NORMAL: pipe_stall=0; pipe_valid grants the rf port to the pipeline; else a non-empty FIFO pops its head onto the port.
REQ-015 In NORMAL: a 3-bit starve counter SHALL increment on each pipeline grant while the FIFO is non-empty, SHALL clear when the FIFO pops or is empty, and on reaching STARVE_LIMIT SHALL move the FSM to DRAIN next cycle.
REQ-016 In DRAIN: pipe_stall=1; the FIFO head SHALL pop; the FSM SHALL return to NORMAL after one pop, with the starve counter cleared.
REQ-017 Granted write SHALL appear on wb_* outputs exactly one cycle after grant; no grant SHALL produce wb_rf_allow=0 and wb_hilo_allow=0, with address/data holding their last values.
REQ-018 wb_rf_allow SHALL be forced to 0 when the granted rfaddr is 0.
REQ-019 HI/LO: a popped entry SHALL drive wb_hilo_allow from its hilo_allow; a pipeline grant SHALL leave wb_hilo_allow=0.
REQ-020 WAW: on a pipeline grant with pipe_rf_allow=1, every FIFO entry (including one pushed the same cycle) with matching nonzero rfaddr SHALL have rf_allow cleared; its HI/LO fields SHALL be unaffected.
REQ-021 pipe_valid=0 SHALL never stall; pipe_stall SHALL depend only on registered FSM state.
REQ-022 A FIFO entry with rf_allow=0 and hilo_allow=0 SHALL still pop normally and output both allows=0.

Reset
REQ-023 On a clk edge with rst_n=0: FIFO count=0, FSM=NORMAL, starve counter=0, all wb_* outputs=0, pipe_stall=0; mdu_ready=1 from the next cycle.
REQ-024 Reset mid-operation SHALL discard queued MDU entries; no write from them SHALL appear after reset.

Verification
REQ-025 pipe_valid=1, rfaddr=5, data=0x1234, allow=1 at cycle N -> cycle N+1: wb_rfaddr_out=5, wb_rf_out=0x1234, wb_rf_allow=1, wb_hilo_allow=0.
REQ-026 Idle pipeline, MDU pushes addr=0, hilo_allow=1, hi=0xA, lo=0xB -> one cycle after pop: wb_hilo_allow=1, hi=0xA, lo=0xB, wb_rf_allow=0.
REQ-027 pipe_valid held 1, one MDU entry queued -> 4 pipeline grants, then pipe_stall=1 for exactly 1 cycle, MDU result written, then pipeline resumes.
REQ-028 Three back-to-back MDU pushes while pipe_valid=1 -> mdu_ready=0 after the second push; the third is held until a pop, with no loss or duplication.
REQ-029 FIFO holds addr=7, rf_allow=1; pipeline writes addr 7 -> popped entry outputs wb_rf_allow=0.
REQ-030 rst_n=0 with 2 entries queued -> count=0, mdu_ready=1 next cycle, no MDU write ever emitted.
